// File: rtl/rst_pkg.sv
// rst_pkg -- shared definitions for the reset sequencer.
//   state_e     : sequencer FSM states
//   CAUSE_*     : bit positions inside the sticky reset-cause register
package rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam int unsigned CAUSE_PAD  = 0;
  localparam int unsigned CAUSE_WDOG = 1;
  localparam int unsigned CAUSE_SOFT = 2;

endpackage

// File: rtl/rst_seq_pulse.sv
// rst_seq_pulse -- per-domain soft-reset pulse generator.
//   HCLK    : clock
//   HRESET  : synchronous active-high reset
//   clr     : abort any pulse in progress (core not ok / sequencer asserting)
//   req     : soft-reset request for this domain
//   active  : requests are accepted only while high
//   rstn_o  : low while the pulse counter is non-zero
module rst_seq_pulse #(
  parameter int unsigned SOFT_LEN = 3
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic clr,
  input  logic req,
  input  logic active,
  output logic rstn_o
);

  logic [3:0] cnt_q, cnt_d;

  // A request while already counting reloads the count, extending the pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (active && req) begin
      cnt_d = 4'(SOFT_LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rstn_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq.sv
// rst_seq -- staggered multi-domain reset sequencer.
//   HCLK, HRESET    : clock, synchronous active-high reset
//   pad_nRST        : external active-low reset (asynchronous, synchronised here)
//   ddrc_init_done  : DDR controller ready
//   watchdog_reset  : watchdog reset request
//   SYSRESETREQ     : per-domain soft-reset requests (honoured only in RUN)
//   cause_clr       : clears the sticky cause register
//   DBGRESETn       : debug reset, released after the stretch period
//   rstn            : per-domain resets, released one by one STAGGER apart
//   busy            : high whenever the sequencer is not in RUN
//   cause           : sticky reset cause {soft, watchdog, pad}
module rst_seq
  import rst_pkg::*;
#(
  parameter int unsigned N_DOM       = 4,
  parameter int unsigned STRETCH_CNT = 42,
  parameter int unsigned STAGGER     = 3,
  parameter int unsigned SOFT_LEN    = 3
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             pad_nRST,
  input  logic             ddrc_init_done,
  input  logic             watchdog_reset,
  input  logic [N_DOM-1:0] SYSRESETREQ,
  input  logic             cause_clr,
  output logic             DBGRESETn,
  output logic [N_DOM-1:0] rstn,
  output logic             busy,
  output logic [2:0]       cause
);

  localparam int unsigned IDX_W = 5;

  logic             pad_meta_q, pad_sync_q;
  logic             core_ok;
  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       timer_q, timer_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dbg_q, dbg_d;
  logic [N_DOM-1:0] rel_q, rel_d;
  logic             busy_q, busy_d;
  logic [2:0]       cause_q, cause_d, cause_set;
  logic [N_DOM-1:0] soft_rstn;
  logic             pulse_clr, pulse_active;

  assign core_ok = ddrc_init_done & ~watchdog_reset & pad_sync_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    dbg_d   = dbg_q;
    rel_d   = rel_q;
    if (!core_ok) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      timer_d = '0;
      idx_d   = '0;
      dbg_d   = 1'b0;
      rel_d   = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
          dbg_d   = 1'b0;
          rel_d   = '0;
        end
        ST_STRETCH: begin
          if (cnt_q == 8'(STRETCH_CNT - 1)) begin
            state_d = ST_RELEASE;
            dbg_d   = 1'b1;
            timer_d = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_RELEASE: begin
          if (timer_q == 4'(STAGGER - 1)) begin
            timer_d = '0;
            idx_d   = idx_q + IDX_W'(1);
            for (int unsigned i = 0; i < N_DOM; i++) begin
              if (idx_q == IDX_W'(i)) rel_d[i] = 1'b1;
            end
            // Last domain released on the same edge that RUN is entered.
            if (idx_q == IDX_W'(N_DOM - 1)) state_d = ST_RUN;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
        ST_RUN: begin
        end
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  assign busy_d = (state_d != ST_RUN);

  // Pad fall detected one stage early so the cause bit sets on the same
  // edge that pad_sync drops.
  always_comb begin
    cause_set             = '0;
    cause_set[CAUSE_PAD]  = pad_sync_q & ~pad_meta_q;
    cause_set[CAUSE_WDOG] = watchdog_reset;
    cause_set[CAUSE_SOFT] = pulse_active & (|SYSRESETREQ);
    cause_d = (cause_clr ? 3'b000 : cause_q) | cause_set;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pad_meta_q <= 1'b0;
      pad_sync_q <= 1'b0;
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      timer_q    <= '0;
      idx_q      <= '0;
      dbg_q      <= 1'b0;
      rel_q      <= '0;
      busy_q     <= 1'b1;
      cause_q    <= '0;
    end else begin
      pad_meta_q <= pad_nRST;
      pad_sync_q <= pad_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      dbg_q      <= dbg_d;
      rel_q      <= rel_d;
      busy_q     <= busy_d;
      cause_q    <= cause_d;
    end
  end

  assign pulse_active = (state_q == ST_RUN) & core_ok;
  assign pulse_clr    = ~core_ok | (state_q == ST_ASSERT);

  for (genvar g = 0; g < N_DOM; g++) begin : g_pulse
    rst_seq_pulse #(.SOFT_LEN(SOFT_LEN)) u_pulse (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .clr    (pulse_clr),
      .req    (SYSRESETREQ[g]),
      .active (pulse_active),
      .rstn_o (soft_rstn[g])
    );
  end

  assign DBGRESETn = dbg_q;
  assign rstn      = rel_q & soft_rstn;
  assign busy      = busy_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       pad_nRST = 1'b0;
  logic       ddrc_init_done = 1'b0;
  logic       watchdog_reset = 1'b0;
  logic [3:0] SYSRESETREQ = 4'b0000;
  logic       cause_clr = 1'b0;
  logic       DBGRESETn;
  logic [3:0] rstn;
  logic       busy;
  logic [2:0] cause;

  rst_seq #(.N_DOM(4), .STRETCH_CNT(42), .STAGGER(3), .SOFT_LEN(3)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .pad_nRST       (pad_nRST),
    .ddrc_init_done (ddrc_init_done),
    .watchdog_reset (watchdog_reset),
    .SYSRESETREQ    (SYSRESETREQ),
    .cause_clr      (cause_clr),
    .DBGRESETn      (DBGRESETn),
    .rstn           (rstn),
    .busy           (busy),
    .cause          (cause)
  );

  initial forever #5 HCLK = ~HCLK;

  typedef struct {
    string      name;
    int         at;
    logic       dbg;
    logic [3:0] rstn;
    logic       busy;
    logic [2:0] cause;
    logic       cc;     // compare cause as well
  } exp_t;

  // release-sequence table: offsets from the cycle ddrc_init_done rises
  typedef struct {
    int         off;
    logic       dbg;
    logic [3:0] rstn;
    logic       busy;
  } rel_vec_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic expect_at(input string name, input int at, input logic dbg,
                           input logic [3:0] r, input logic b,
                           input logic [2:0] c, input logic cc);
    exp_t e;
    e.name = name; e.at = at; e.dbg = dbg; e.rstn = r; e.busy = b;
    e.cause = c; e.cc = cc;
    exp_q.push_back(e);
  endtask

  // advance to 2 time units after clock edge number c
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge HCLK);
      #2;
    end
  endtask

  // monitor: counts edges, compares due expectations 1 unit after each edge
  initial forever begin
    @(posedge HCLK);
    cyc = cyc + 1;
    #1;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at <= cyc) begin
        exp_t e;
        e = exp_q[i];
        exp_q.delete(i);
        vectors++;
        if (e.at < cyc || DBGRESETn !== e.dbg || rstn !== e.rstn || busy !== e.busy ||
            (e.cc && cause !== e.cause)) begin
          miscompares++;
          $display("FAIL %s @cyc %0d: got dbg=%b rstn=%b busy=%b cause=%b, want dbg=%b rstn=%b busy=%b cause=%b%s",
                   e.name, cyc, DBGRESETn, rstn, busy, cause, e.dbg, e.rstn, e.busy,
                   e.cause, e.cc ? "" : "(ignored)");
        end
      end
    end
  end

  initial begin
    rel_vec_t tbl[9];
    int t;
    tbl[0] = '{42, 1'b0, 4'b0000, 1'b1};
    tbl[1] = '{43, 1'b1, 4'b0000, 1'b1};
    tbl[2] = '{45, 1'b1, 4'b0000, 1'b1};
    tbl[3] = '{46, 1'b1, 4'b0001, 1'b1};
    tbl[4] = '{48, 1'b1, 4'b0001, 1'b1};
    tbl[5] = '{49, 1'b1, 4'b0011, 1'b1};
    tbl[6] = '{52, 1'b1, 4'b0111, 1'b1};
    tbl[7] = '{54, 1'b1, 4'b0111, 1'b1};
    tbl[8] = '{55, 1'b1, 4'b1111, 1'b0};

    // reset state
    goto(2);
    expect_at("reset", 3, 1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);
    goto(4);
    HRESET = 1'b0; pad_nRST = 1'b1;
    expect_at("idle_no_ddr", 8, 1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);

    // power-up sequence from table
    goto(10);
    t = cyc;
    ddrc_init_done = 1'b1;
    for (int i = 0; i < 9; i++)
      expect_at($sformatf("release_T+%0d", tbl[i].off), t + tbl[i].off,
                tbl[i].dbg, tbl[i].rstn, tbl[i].busy, 3'b000, 1'b1);

    // parallel soft resets on domains 0 and 2
    goto(70);
    SYSRESETREQ = 4'b0101;
    for (int k = 1; k <= 3; k++)
      expect_at("soft0101_low", 70 + k, 1'b1, 4'b1010, 1'b0, 3'b100, 1'b1);
    expect_at("soft0101_rel", 74, 1'b1, 4'b1111, 1'b0, 3'b100, 1'b1);
    goto(71);
    SYSRESETREQ = 4'b0000;
    goto(76);
    cause_clr = 1'b1;
    expect_at("cause_clr", 77, 1'b1, 4'b1111, 1'b0, 3'b000, 1'b1);
    goto(77);
    cause_clr = 1'b0;

    // re-pulse domain 3 two cycles into its own pulse
    goto(80);
    SYSRESETREQ = 4'b1000;
    for (int k = 1; k <= 5; k++)
      expect_at("repulse_low", 80 + k, 1'b1, 4'b0111, 1'b0, 3'b100, 1'b1);
    expect_at("repulse_rel", 86, 1'b1, 4'b1111, 1'b0, 3'b100, 1'b1);
    goto(81); SYSRESETREQ = 4'b0000;
    goto(82); SYSRESETREQ = 4'b1000;
    goto(83); SYSRESETREQ = 4'b0000;
    goto(88); cause_clr = 1'b1;
    expect_at("cause_clr2", 89, 1'b1, 4'b1111, 1'b0, 3'b000, 1'b1);
    goto(89); cause_clr = 1'b0;

    // one-cycle pad glitch in RUN, with soft request racing cause_clr
    goto(90);
    pad_nRST = 1'b0; SYSRESETREQ = 4'b0001; cause_clr = 1'b1;
    expect_at("pad_set_wins", 91, 1'b1, 4'b1110, 1'b0, 3'b100, 1'b1);
    expect_at("pad_sync_fall", 92, 1'b1, 4'b1110, 1'b0, 3'b101, 1'b1);
    expect_at("pad_assert", 93, 1'b0, 4'b0000, 1'b1, 3'b101, 1'b1);
    goto(91);
    pad_nRST = 1'b1; SYSRESETREQ = 4'b0000; cause_clr = 1'b0;
    goto(100); cause_clr = 1'b1;
    expect_at("cause_clr3", 101, 1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);
    goto(101); cause_clr = 1'b0;
    expect_at("pad_restart_dbg0", 135, 1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);
    expect_at("pad_restart_dbg1", 136, 1'b1, 4'b0000, 1'b1, 3'b000, 1'b1);
    expect_at("pad_restart_r1", 142, 1'b1, 4'b0011, 1'b1, 3'b000, 1'b1);

    // watchdog during RELEASE after rstn[1] has risen
    goto(143); watchdog_reset = 1'b1;
    expect_at("wdog_assert", 144, 1'b0, 4'b0000, 1'b1, 3'b010, 1'b1);
    goto(144); watchdog_reset = 1'b0;
    expect_at("wdog_dbg0", 186, 1'b0, 4'b0000, 1'b1, 3'b010, 1'b1);
    expect_at("wdog_dbg1", 187, 1'b1, 4'b0000, 1'b1, 3'b010, 1'b1);
    expect_at("wdog_r2", 198, 1'b1, 4'b0111, 1'b1, 3'b010, 1'b1);
    expect_at("wdog_run", 199, 1'b1, 4'b1111, 1'b0, 3'b010, 1'b1);

    // HRESET mid-STRETCH; soft requests ignored outside RUN
    goto(210); ddrc_init_done = 1'b0;
    expect_at("ddr_drop", 211, 1'b0, 4'b0000, 1'b1, 3'b010, 1'b0);
    goto(211); ddrc_init_done = 1'b1;
    goto(220); HRESET = 1'b1;
    expect_at("hreset_mid", 221, 1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);
    goto(221); HRESET = 1'b0;
    goto(230); SYSRESETREQ = 4'b1111;
    expect_at("soft_ignored", 231, 1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);
    goto(231); SYSRESETREQ = 4'b0000;
    expect_at("hr_dbg0", 265, 1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);
    expect_at("hr_dbg1", 266, 1'b1, 4'b0000, 1'b1, 3'b000, 1'b1);
    expect_at("hr_run", 278, 1'b1, 4'b1111, 1'b0, 3'b000, 1'b1);

    goto(285);
    vectors++;
    if (DBGRESETn !== 1'b1) begin
      miscompares++;
      $display("FAIL final_dbg: got %b want 1", DBGRESETn);
    end
    vectors++;
    if (rstn !== 4'b1111) begin
      miscompares++;
      $display("FAIL final_rstn: got %b want 1111", rstn);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL final_busy: got %b want 0", busy);
    end
    vectors++;
    if (cause !== 3'b000) begin
      miscompares++;
      $display("FAIL final_cause: got %b want 000", cause);
    end
    while (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: expectation for cycle %0d never compared", exp_q[0].name, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
